// File: rtl/lifo_stack.sv
// LIFO stack for the forth core: registered top-of-stack with a DEPTH-1 entry array below it.
// Define STACK_ERR_EN to add sticky overflow/underflow flags and the err_clr input.
module lifo_stack #(
   parameter int WIDTH = 8,
   parameter int DEPTH = 16,
   localparam int CW = $clog2(DEPTH + 1)
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             push,
   input  logic             pop,
   input  logic [WIDTH-1:0] wdata,
   output logic [WIDTH-1:0] rdata,
   output logic [CW-1:0]    count,
   output logic             empty,
   output logic             full
`ifdef STACK_ERR_EN
   ,
   output logic             overflow,
   output logic             underflow,
   input  logic             err_clr
`endif
);

   localparam int AW = (DEPTH > 2) ? $clog2(DEPTH - 1) : 1;

   logic [WIDTH-1:0] mem_q [DEPTH-1];
   logic [WIDTH-1:0] tos_q, tos_d;
   logic [CW-1:0]    count_q, count_d;
   logic [CW-1:0]    cnt_m1, cnt_m2;
   logic [AW-1:0]    wr_idx, rd_idx;
   logic             mem_we;
   logic             is_empty, is_full;
   logic             ovf_evt, unf_evt;

   assign is_empty = (count_q == '0);
   assign is_full  = (count_q == CW'(DEPTH));
   assign cnt_m1   = count_q - CW'(1);
   assign cnt_m2   = count_q - CW'(2);
   assign wr_idx   = cnt_m1[AW-1:0];
   assign rd_idx   = cnt_m2[AW-1:0];

   assign ovf_evt  = push & ~pop & is_full;
   assign unf_evt  = pop & is_empty;

   // push+pop on a non-empty stack only replaces TOS; on an empty stack it falls through to a plain push
   always_comb begin
      tos_d   = tos_q;
      count_d = count_q;
      mem_we  = 1'b0;
      if (push && pop && !is_empty) begin
         tos_d = wdata;
      end else if (push && !is_full) begin
         mem_we  = !is_empty;
         tos_d   = wdata;
         count_d = count_q + CW'(1);
      end else if (pop && !push && !is_empty) begin
         tos_d   = (count_q >= CW'(2)) ? mem_q[rd_idx] : '0;
         count_d = cnt_m1;
      end
   end

   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         tos_q   <= '0;
         count_q <= '0;
      end else begin
         tos_q   <= tos_d;
         count_q <= count_d;
      end
   end

   always_ff @(posedge clk) begin
      if (mem_we) begin
         mem_q[wr_idx] <= tos_q;
      end
   end

   assign rdata = tos_q;
   assign count = count_q;
   assign empty = is_empty;
   assign full  = is_full;

`ifdef STACK_ERR_EN
   logic ovf_q, unf_q;

   // a new event in the same cycle as err_clr keeps the flag set
   always_ff @(posedge clk or negedge rst) begin
      if (!rst) begin
         ovf_q <= 1'b0;
         unf_q <= 1'b0;
      end else begin
         ovf_q <= ovf_evt | (ovf_q & ~err_clr);
         unf_q <= unf_evt | (unf_q & ~err_clr);
      end
   end

   assign overflow  = ovf_q;
   assign underflow = unf_q;
`else
   logic unused_evt;
   assign unused_evt = ovf_evt ^ unf_evt;
`endif

endmodule
